// File: rtl/poly_disp_seq.sv
// poly_disp_seq: frame scheduler for the polyphonic note-display accumulator.
// Walks the voice table two voices per step, drives the accumulator with one
// voice pair per ACC cycle, seeds/closes the chain and latches the frame word.
//
// Optional build macro: POLY_DISP_SEQ_CHANGE_ONLY_EN
//   defined   -> frame_valid_out pulses only when the frame word changed
//                (the first frame after reset always pulses)
//   undefined -> frame_valid_out pulses after every completed scan
//
// state | meaning
// IDLE  | waiting for a frame strobe (or a pending one)
// RD1   | even-voice address 2k presented to the voice table
// RD2   | odd-voice address 2k+1 presented, even-voice data captured
// ACC   | voice pair k driven to the accumulator
// DRAIN | accumulator output complete, latch frame word
module poly_disp_seq #(
   parameter int NUM_PAIRS = 8,
   parameter int NOTE_BASE = 36
) (
   input  logic                             clk,
   input  logic                             reset,
   input  logic                             start_in,
   output logic [$clog2(2*NUM_PAIRS)-1:0]   voice_addr_out,
   input  logic [6:0]                       voice_note_in,
   input  logic                             voice_on_in,
   output logic [7:0]                       ii_out,
   output logic                             sq1_no_out,
   output logic                             sq2_no_out,
   output logic [6:0]                       sq1_n_out,
   output logic [6:0]                       sq2_n_out,
   output logic [32*NUM_PAIRS-1:0]          pd_seed_out,
   input  logic [32*NUM_PAIRS-1:0]          pd_ret_in,
   output logic [32*NUM_PAIRS-1:0]          frame_pd_out,
   output logic                             frame_valid_out,
   output logic                             busy_out
);

   localparam int AW = $clog2(2*NUM_PAIRS);
   localparam logic [AW-1:0] K_ONE  = AW'(1);
   localparam logic [AW-1:0] K_LAST = AW'(NUM_PAIRS-1);
   localparam logic [6:0]    NB7    = 7'(NOTE_BASE);

   typedef enum logic [2:0] {IDLE, RD1, RD2, ACC, DRAIN} state_t;

   state_t         state;
   logic           pending;
   logic [AW-1:0]  k;
   logic [AW-1:0]  k_next;
   logic [6:0]     even_note;
   logic           even_on;
`ifdef POLY_DISP_SEQ_CHANGE_ONLY_EN
   logic           first_frame;
`endif

   // Notes below the displayable range would borrow into the neighbouring slot.
   function automatic logic [6:0] clamp_note(input logic [6:0] n);
      return (n < NB7) ? NB7 : n;
   endfunction

   assign k_next = k + K_ONE;

   // Scan sequencer: state, pair counter, table address, pending strobe, frame latch.
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= IDLE;
         pending         <= 1'b0;
         k               <= '0;
         voice_addr_out  <= '0;
         ii_out          <= '0;
         even_note       <= NB7;
         even_on         <= 1'b0;
         frame_pd_out    <= '0;
         frame_valid_out <= 1'b0;
         busy_out        <= 1'b0;
`ifdef POLY_DISP_SEQ_CHANGE_ONLY_EN
         first_frame     <= 1'b1;
`endif
      end else begin
         frame_valid_out <= 1'b0;
         // Strobes during a scan (DRAIN included) collapse into one pending scan.
         if (start_in && state != IDLE)
            pending <= 1'b1;
         case (state)
            IDLE: begin
               if (start_in || pending) begin
                  state          <= RD1;
                  pending        <= 1'b0;
                  k              <= '0;
                  voice_addr_out <= '0;
                  busy_out       <= 1'b1;
               end
            end
            RD1: begin
               voice_addr_out <= AW'({k, 1'b1});
               state          <= RD2;
            end
            RD2: begin
               even_note <= voice_note_in;
               even_on   <= voice_on_in;
               ii_out    <= 8'(k);
               state     <= ACC;
            end
            ACC: begin
               if (k == K_LAST) begin
                  state <= DRAIN;
               end else begin
                  k              <= k_next;
                  voice_addr_out <= AW'({k_next, 1'b0});
                  state          <= RD1;
               end
            end
            DRAIN: begin
               frame_pd_out <= pd_ret_in;
`ifdef POLY_DISP_SEQ_CHANGE_ONLY_EN
               frame_valid_out <= first_frame || (pd_ret_in != frame_pd_out);
               first_frame     <= 1'b0;
`else
               frame_valid_out <= 1'b1;
`endif
               busy_out     <= 1'b0;
               state        <= IDLE;
            end
            default: begin
               state    <= IDLE;
               busy_out <= 1'b0;
            end
         endcase
      end
   end

   // Accumulator drive: pass-through outside ACC; odd voice comes straight off the table read.
   always_comb begin
      sq1_no_out  = 1'b0;
      sq2_no_out  = 1'b0;
      sq1_n_out   = NB7;
      sq2_n_out   = NB7;
      pd_seed_out = pd_ret_in;
      if (state == ACC) begin
         sq1_no_out = even_on;
         sq1_n_out  = clamp_note(even_note);
         sq2_no_out = voice_on_in;
         sq2_n_out  = clamp_note(voice_note_in);
         if (k == '0)
            pd_seed_out = '0;
      end
   end

endmodule

// File: tb/tb_poly_disp_seq.sv
// tb_poly_disp_seq: directed + randomized bench for poly_disp_seq with a
// voice-table RAM model, an OR-accumulator model and a frame reference model.
module tb_poly_disp_seq;

   localparam int NP = 8;
   localparam int NB = 36;
   localparam int PW = 32*NP;
   localparam int AW = $clog2(2*NP);
`ifdef POLY_DISP_SEQ_CHANGE_ONLY_EN
   localparam bit CO = 1'b1;
`else
   localparam bit CO = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          reset;
   logic          start_in;
   logic [AW-1:0] voice_addr_out;
   logic [6:0]    voice_note_in;
   logic          voice_on_in;
   logic [7:0]    ii_out;
   logic          sq1_no_out, sq2_no_out;
   logic [6:0]    sq1_n_out, sq2_n_out;
   logic [PW-1:0] pd_seed_out, pd_ret_in, frame_pd_out;
   logic          frame_valid_out, busy_out;

   int n_cmp = 0;
   int n_bad = 0;

   logic [6:0]    tbl_note [2*NP];
   logic          tbl_on   [2*NP];
   logic [PW-1:0] prev_frame;
   bit            first_frame;
   logic [PW-1:0] acc_nxt;

   poly_disp_seq #(.NUM_PAIRS(NP), .NOTE_BASE(NB)) dut (
      .clk(clk), .reset(reset), .start_in(start_in),
      .voice_addr_out(voice_addr_out), .voice_note_in(voice_note_in),
      .voice_on_in(voice_on_in), .ii_out(ii_out),
      .sq1_no_out(sq1_no_out), .sq2_no_out(sq2_no_out),
      .sq1_n_out(sq1_n_out), .sq2_n_out(sq2_n_out),
      .pd_seed_out(pd_seed_out), .pd_ret_in(pd_ret_in),
      .frame_pd_out(frame_pd_out), .frame_valid_out(frame_valid_out),
      .busy_out(busy_out)
   );

   always #5 clk = ~clk;

   // Voice table: synchronous read, one cycle latency.
   always @(posedge clk) begin
      voice_note_in <= tbl_note[voice_addr_out];
      voice_on_in   <= tbl_on[voice_addr_out];
   end

   // Accumulator: ORs the pair's slots into the seed, registered.
   always @(posedge clk) begin
      if (reset) begin
         pd_ret_in <= '0;
      end else begin
         acc_nxt = pd_seed_out;
         for (int p = 0; p < NP; p++) begin
            if (ii_out == 8'(p)) begin
               acc_nxt[32*p +: 16] = acc_nxt[32*p +: 16] |
                  16'({sq1_no_out, 2'b00, 7'(sq1_n_out - 7'(NB))});
               acc_nxt[32*p+16 +: 16] = acc_nxt[32*p+16 +: 16] |
                  16'({sq2_no_out, 2'b00, 7'(sq2_n_out - 7'(NB))});
            end
         end
         pd_ret_in <= acc_nxt;
      end
   end

   // Expected display word straight from the table contents.
   function automatic logic [PW-1:0] model_frame();
      logic [PW-1:0] f = '0;
      for (int v = 0; v < 2*NP; v++) begin
         int n = (int'(tbl_note[v]) < NB) ? NB : int'(tbl_note[v]);
         int s = (tbl_on[v] ? 512 : 0) + (n - NB);
         f[16*v +: 16] = 16'(s);
      end
      return f;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_table(input int note, input bit on);
      for (int v = 0; v < 2*NP; v++) begin
         tbl_note[v] = 7'(note);
         tbl_on[v]   = on;
      end
   endtask

   task automatic rand_table();
      for (int v = 0; v < 2*NP; v++) begin
         tbl_note[v] = 7'($urandom_range(0, 127));
         tbl_on[v]   = 1'($urandom_range(0, 1));
      end
   endtask

   // One scan with extra strobes at cycles s1/s2 after the start (0 = none).
   task automatic run_scan(input string tag, input int s1, input int s2);
      logic [PW-1:0] exp;
      bit  p1, p2, multi;
      int  t1, t2, pulses;
      exp    = model_frame();
      multi  = (s1 != 0) || (s2 != 0);
      p1     = !CO || first_frame || (exp != prev_frame);
      p2     = multi && !CO;
      t1     = 0;
      t2     = 0;
      pulses = 0;
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      check({tag, "_busy_rd1"}, busy_out, 1);
      for (int n = 1; n <= (multi ? 60 : 30); n++) begin
         start_in = (n == s1) || (n == s2);
         if (frame_valid_out) begin
            pulses++;
            if (t1 == 0) t1 = n;
            else if (t2 == 0) t2 = n;
         end
         if (multi && n == 26) check({tag, "_idle_gap"}, busy_out, 0);
         if (multi && n == 27) check({tag, "_restart"}, busy_out, 1);
         tick();
      end
      start_in = 1'b0;
      check({tag, "_pulses"}, pulses, (p1 ? 1 : 0) + (p2 ? 1 : 0));
      check({tag, "_lat"}, p1 ? t1 : (p2 ? t2 : t1), p1 ? 26 : (p2 ? 52 : 0));
      if (p1 && p2) check({tag, "_lat2"}, t2, 52);
      check({tag, "_frame"}, frame_pd_out, exp);
      check({tag, "_busy_end"}, busy_out, 0);
      prev_frame  = exp;
      first_frame = 1'b0;
   endtask

   initial begin
      int pulses;
      reset    = 1'b1;
      start_in = 1'b0;
      set_table(60, 1'b0);
      prev_frame  = '0;
      first_frame = 1'b1;
      repeat (3) tick();
      reset = 1'b0;
      tick();

      check("rst_busy", busy_out, 0);
      check("rst_valid", frame_valid_out, 0);
      check("rst_frame", frame_pd_out, 0);
      check("rst_addr", voice_addr_out, 0);
      check("rst_ii", ii_out, 0);
      check("rst_sq_no", {sq1_no_out, sq2_no_out}, 0);
      check("rst_sq1_n", sq1_n_out, NB);
      check("rst_sq2_n", sq2_n_out, NB);
      check("rst_seed_pass", pd_seed_out, pd_ret_in);

      run_scan("all_off60", 0, 0);
      check("all_off60_slot0", frame_pd_out[15:0], 16'h0018);
      check("all_off60_slot15", frame_pd_out[255:240], 16'h0018);

      set_table(NB, 1'b0);
      tbl_note[0] = 7'd60; tbl_on[0] = 1'b1;
      tbl_note[3] = 7'd72; tbl_on[3] = 1'b1;
      tick();
      run_scan("two_on", 0, 0);
      check("two_on_slot0", frame_pd_out[15:0], 16'h0218);
      check("two_on_slot3", frame_pd_out[63:48], 16'h0224);
      check("two_on_slot1", frame_pd_out[31:16], 16'h0000);

      tbl_note[5] = 7'd20; tbl_on[5] = 1'b1;
      run_scan("clamp", 0, 0);
      check("clamp_slot5", frame_pd_out[95:80], 16'h0200);
      check("clamp_slot4", frame_pd_out[79:64], 16'h0000);
      check("clamp_slot6", frame_pd_out[111:96], 16'h0000);

      rand_table();
      run_scan("pending", 5, 10);
      rand_table();
      run_scan("drain_start", 25, 25);

      rand_table();
      start_in = 1'b1;
      tick();
      start_in = 1'b0;
      repeat (11) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      check("midrst_busy", busy_out, 0);
      check("midrst_frame", frame_pd_out, 0);
      check("midrst_valid", frame_valid_out, 0);
      pulses = 0;
      for (int n = 0; n < 30; n++) begin
         if (frame_valid_out) pulses++;
         tick();
      end
      check("midrst_nopulse", pulses, 0);
      prev_frame  = '0;
      first_frame = 1'b1;
      run_scan("after_rst", 0, 0);

      for (int i = 0; i < 5; i++) begin
         rand_table();
         repeat ($urandom_range(0, 4)) tick();
         run_scan($sformatf("rand%0d", i), 0, 0);
      end

      run_scan("same_a", 0, 0);
      run_scan("same_b", 0, 0);
      tbl_note[1] = 7'd64; tbl_on[1] = 1'b1;
      run_scan("v1_change", 0, 0);
      check("v1_change_slot1", frame_pd_out[31:16], 16'h021C);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/poly_disp_seq.md
Name: poly_disp_seq

Overview:
Frame scheduler for the polyphonic note-display accumulator. On each frame strobe it walks the voice table two voices at a time and drives the accumulator's ii, note and note-on inputs once per voice pair. It seeds and closes the accumulation chain, so the completed display word is latched once per frame for the video overlay. It sits between the voice-state table (synchronous read RAM) and the accumulator.

Parameters:
NUM_PAIRS, 8, voice pairs per frame (voices = 2*NUM_PAIRS; display word = 32*NUM_PAIRS bits)
NOTE_BASE, 36, lowest displayable MIDI note; the accumulator subtracts this value

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start_in  in  1  frame strobe (one-cycle pulse, e.g. vblank edge)
voice_addr_out  out  $clog2(2*NUM_PAIRS)  voice table read address; data returns the next cycle
voice_note_in  in  7  note of the addressed voice (1-cycle read latency)
voice_on_in  in  1  note-on flag of the addressed voice (1-cycle read latency)
ii_out  out  8  pair index to the accumulator
sq1_no_out  out  1  note-on, even voice of the pair
sq2_no_out  out  1  note-on, odd voice of the pair
sq1_n_out  out  7  note, even voice
sq2_n_out  out  7  note, odd voice
pd_seed_out  out  32*NUM_PAIRS  accumulator pd input
pd_ret_in  in  32*NUM_PAIRS  accumulator registered pd output
frame_pd_out  out  32*NUM_PAIRS  latched completed display word
frame_valid_out  out  1  one-cycle pulse when frame_pd_out updates
busy_out  out  1  high while a scan is in progress

Behaviour:
- Reset values: state IDLE, pair counter k=0, pending=0, frame_pd_out=0, frame_valid_out=0, busy_out=0, voice_addr_out=0, ii_out=0.
- Hold mode (every cycle except ACC):
  - sq1_no_out=sq2_no_out=0 and sq1_n_out=sq2_n_out=NOTE_BASE.
  - pd_seed_out=pd_ret_in, so the accumulator passes its value through unchanged.
- Slot encoding produced by the accumulator: each 16-bit slot holds [6:0]=note-NOTE_BASE and [9]=note-on. Slot 2k is the even voice; slot 2k+1 is the odd voice.
- FSM states: IDLE, RD1, RD2, ACC, DRAIN.
  - IDLE: on start_in or pending, go to RD1, clear pending, set k=0.
  - RD1: voice_addr_out=2k.
  - RD2: voice_addr_out=2k+1. Register voice_note_in and voice_on_in as the even-voice pair.
  - ACC:
    - ii_out=k.
    - Even voice is driven from the register; odd voice is driven directly from voice_note_in and voice_on_in.
    - pd_seed_out = 0 when k=0, else pd_ret_in.
    - If k=NUM_PAIRS-1, go to DRAIN; else k++ and go to RD1.
  - DRAIN: frame_pd_out<=pd_ret_in, frame_valid_out<=1 on the next cycle, then go to IDLE.
- Note clamp: any note < NOTE_BASE is driven as NOTE_BASE with its note-on preserved. This prevents underflow into adjacent slots.
- Latency: start_in high in cycle T gives:
  - RD1 in T+1;
  - last ACC in T+3*NUM_PAIRS;
  - DRAIN in T+3*NUM_PAIRS+1;
  - frame_valid_out in T+3*NUM_PAIRS+2 (T+26 for the default).
- busy_out is high from RD1 through DRAIN inclusive.
- start_in while busy sets pending; repeated strobes collapse to a single pending scan. The pending scan starts from IDLE on the cycle after the previous scan's DRAIN.
- start_in in the DRAIN cycle is treated as pending, giving a back-to-back scan.
- Reset mid-scan: all state returns to reset values. The partial frame is discarded, frame_pd_out=0, and no frame_valid_out pulse is issued.
- frame_pd_out holds its value between frames.

Optional Feature:
POLY_DISP_SEQ_CHANGE_ONLY_EN
- Defined: in DRAIN, frame_pd_out is still updated, but frame_valid_out pulses only if pd_ret_in differs from the previous frame_pd_out. The first frame after reset always pulses.
- Undefined: frame_valid_out pulses after every completed scan.

Test Plan:
- Reset, table all voices off at note 60, start_in pulse at T → frame_valid_out at T+26; frame_pd_out has every slot = 0x0018 (bit9=0, note field 24).
- Voice0=60 on, voice3=72 on, others off at note 36, start_in → slot0=0x0218, slot3=0x0224, other slots 0x0000.
- Voice5 note 20 on → slot5=0x0200 (clamped); slots 4 and 6 unaffected.
- start_in pulses at T+5 and T+10 during a scan → exactly one extra scan, starting the cycle after DRAIN; two frame_valid_out pulses total.
- reset asserted at T+12 mid-scan → busy_out=0, frame_pd_out=0, no frame_valid_out; a subsequent start_in yields a correct frame.
- POLY_DISP_SEQ_CHANGE_ONLY_EN defined, two scans of an unchanged table → one frame_valid_out pulse. Change voice1 to 64 on → the next scan pulses with slot1=0x021C.
